// File: rtl/eq_fir_perif_if.sv
// Command/status bus of the multi-band FIR equalizer: select, enable, write,
// command word in and status word out.
interface eq_fir_perif_if;
  logic        PSel;
  logic        PEnable;
  logic        PWrite;
  logic [31:0] PWData;
  logic [31:0] PRData;

  modport master (output PSel, output PEnable, output PWrite, output PWData, input PRData);
  modport slave  (input PSel, input PEnable, input PWrite, input PWData, output PRData);
endinterface

// File: rtl/eq_fir_perif.sv
// Multi-band FIR equalizer: NumBands coefficient banks share one sample history,
// each band is scaled by its own gain and the bands are summed into one saturated sample.
module eq_fir_perif #(
  parameter int NumBands  = 10,
  parameter int DataWidth = 16,
  parameter int TapsBits  = 9,
  parameter int MaxTaps   = 281,
  parameter int GainFrac  = 14
) (
  input  logic           Clk,
  input  logic           Reset,
  eq_fir_perif_if.slave  bus
);

  localparam int ProdW = 2 * DataWidth;
  localparam int AccW  = 2 * DataWidth + TapsBits;
  localparam int SumW  = 2 * DataWidth + 4;
  localparam int HistW = $clog2(MaxTaps);
  localparam int CoefN = NumBands * MaxTaps;
  localparam int CptrW = $clog2(CoefN + 1);
  localparam int BandW = 4;

  localparam logic [2:0] OP_SET_TAPS = 3'b001;
  localparam logic [2:0] OP_LOAD     = 3'b010;
  localparam logic [2:0] OP_SET_GAIN = 3'b011;
  localparam logic [2:0] OP_SAMPLE   = 3'b100;

  localparam logic signed [AccW-1:0] SAT_MAX = {{(AccW-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [AccW-1:0] SAT_MIN = {{(AccW-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};
  localparam logic signed [DataWidth-1:0] GAIN_UNITY = {{(DataWidth-GainFrac-1){1'b0}}, 1'b1, {GainFrac{1'b0}}};
  localparam logic [TapsBits-1:0] TAPS_ONE   = {{(TapsBits-1){1'b0}}, 1'b1};
  localparam logic [TapsBits-1:0] TAPS_MAX   = TapsBits'(MaxTaps);
  localparam logic [HistW-1:0]    HIST_ONE   = {{(HistW-1){1'b0}}, 1'b1};
  localparam logic [HistW-1:0]    HIST_LAST  = HistW'(MaxTaps - 1);
  localparam logic [CptrW-1:0]    CPTR_ONE   = {{(CptrW-1){1'b0}}, 1'b1};
  localparam logic [BandW-1:0]    BAND_ONE   = {{(BandW-1){1'b0}}, 1'b1};
  localparam logic [BandW-1:0]    BAND_LAST  = BandW'(NumBands - 1);
  localparam logic [BandW:0]      BAND_LIMIT = (BandW+1)'(NumBands);

  typedef enum logic [2:0] {
    ST_CLEAR, ST_IDLE, ST_MAC, ST_BSCALE, ST_GAIN, ST_OUTPUT
  } state_t;

  function automatic logic signed [DataWidth-1:0] sat_dw(input logic signed [AccW-1:0] v);
    logic signed [DataWidth-1:0] res;
    if (v > SAT_MAX) begin
      res = SAT_MAX[DataWidth-1:0];
    end else if (v < SAT_MIN) begin
      res = SAT_MIN[DataWidth-1:0];
    end else begin
      res = v[DataWidth-1:0];
    end
    return res;
  endfunction

  state_t r_state, w_state_nxt;

  logic signed [DataWidth-1:0] r_hist [MaxTaps];
  logic signed [DataWidth-1:0] r_cram [CoefN];
  logic signed [DataWidth-1:0] r_gain [NumBands];

  logic                        r_ready, r_ovf, r_drop;
  logic signed [DataWidth-1:0] r_y, r_bval;
  logic [TapsBits-1:0]         r_taps, r_k;
  logic [CptrW-1:0]            r_cptr, r_cidx;
  logic [HistW-1:0]            r_wp, r_hidx, r_clr;
  logic [BandW-1:0]            r_band;
  logic signed [AccW-1:0]      r_acc;
  logic signed [SumW-1:0]      r_sum;

  logic                        w_cmd, w_acc, w_sample, w_taps_ok, w_k_last, w_unused;
  logic [2:0]                  w_op;
  logic signed [DataWidth-1:0] w_data;
  logic [TapsBits-1:0]         w_taps_in;
  logic [BandW-1:0]            w_gidx;
  logic [CptrW-1:0]            w_coef_lim;
  logic signed [ProdW-1:0]     w_prod, w_gprod, w_gsh;
  logic signed [AccW-1:0]      w_acc_sh;

  assign w_cmd      = bus.PSel & bus.PEnable & bus.PWrite;
  assign w_acc      = w_cmd & r_ready;
  assign w_op       = bus.PWData[2:0];
  assign w_data     = bus.PWData[18:3];
  assign w_taps_in  = bus.PWData[3 +: TapsBits];
  assign w_gidx     = bus.PWData[22:19];
  assign w_unused   = ^bus.PWData[31:23];
  assign w_sample   = w_acc && (w_op == OP_SAMPLE);
  assign w_taps_ok  = (w_taps_in != {TapsBits{1'b0}}) && (w_taps_in <= TAPS_MAX);
  assign w_coef_lim = CptrW'(NumBands) * CptrW'(r_taps);
  assign w_k_last   = (r_k == (r_taps - TAPS_ONE));

  // Operands are sign-extended to full product width before multiplying.
  assign w_prod   = $signed({{DataWidth{r_cram[r_cidx][DataWidth-1]}}, r_cram[r_cidx]})
                  * $signed({{DataWidth{r_hist[r_hidx][DataWidth-1]}}, r_hist[r_hidx]});
  assign w_gprod  = $signed({{DataWidth{r_bval[DataWidth-1]}}, r_bval})
                  * $signed({{DataWidth{r_gain[r_band][DataWidth-1]}}, r_gain[r_band]});
  assign w_gsh    = w_gprod >>> GainFrac;
  assign w_acc_sh = r_acc >>> (DataWidth - 1);

  assign bus.PRData = {r_ready, r_ovf, r_drop, {(29-DataWidth){1'b0}}, r_y};

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR:  if (r_clr == HIST_LAST) w_state_nxt = ST_IDLE;   else w_state_nxt = ST_CLEAR;
      ST_IDLE:   if (w_sample)           w_state_nxt = ST_MAC;    else w_state_nxt = ST_IDLE;
      ST_MAC:    if (w_k_last)           w_state_nxt = ST_BSCALE; else w_state_nxt = ST_MAC;
      ST_BSCALE: w_state_nxt = ST_GAIN;
      ST_GAIN:   if (r_band == BAND_LAST) w_state_nxt = ST_OUTPUT; else w_state_nxt = ST_MAC;
      ST_OUTPUT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_CLEAR;
    endcase
  end

  // Command decode, status bits and the MAC/gain/output datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ready <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
      r_y     <= {DataWidth{1'b0}};
      r_bval  <= {DataWidth{1'b0}};
      r_taps  <= TAPS_ONE;
      r_k     <= {TapsBits{1'b0}};
      r_cptr  <= {CptrW{1'b0}};
      r_cidx  <= {CptrW{1'b0}};
      r_wp    <= {HistW{1'b0}};
      r_hidx  <= {HistW{1'b0}};
      r_clr   <= {HistW{1'b0}};
      r_band  <= {BandW{1'b0}};
      r_acc   <= {AccW{1'b0}};
      r_sum   <= {SumW{1'b0}};
      for (int i = 0; i < NumBands; i++) r_gain[i] <= GAIN_UNITY;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE);
      if (w_cmd && !r_ready) r_drop <= 1'b1;
      if (w_acc) begin
        case (w_op)
          OP_SET_TAPS: begin
            if (w_taps_ok) begin
              r_taps <= w_taps_in;
              r_cptr <= {CptrW{1'b0}};
              r_ovf  <= 1'b0;
              r_drop <= 1'b0;
            end else begin
              r_ovf  <= 1'b1;
            end
          end
          OP_LOAD: begin
            if (r_cptr < w_coef_lim) r_cptr <= r_cptr + CPTR_ONE;
            else                     r_ovf  <= 1'b1;
          end
          OP_SET_GAIN: begin
            if ({1'b0, w_gidx} < BAND_LIMIT) r_gain[w_gidx] <= w_data;
          end
          OP_SAMPLE: begin
            r_k    <= {TapsBits{1'b0}};
            r_band <= {BandW{1'b0}};
            r_cidx <= {CptrW{1'b0}};
            r_hidx <= r_wp;
          end
          default: ;
        endcase
      end
      case (r_state)
        ST_CLEAR: r_clr <= r_clr + HIST_ONE;
        ST_MAC: begin
          r_acc  <= r_acc + {{(AccW-ProdW){w_prod[ProdW-1]}}, w_prod};
          r_cidx <= r_cidx + CPTR_ONE;
          r_hidx <= (r_hidx == {HistW{1'b0}}) ? HIST_LAST : (r_hidx - HIST_ONE);
          r_k    <= r_k + TAPS_ONE;
        end
        ST_BSCALE: begin
          r_bval <= sat_dw(w_acc_sh);
          r_acc  <= {AccW{1'b0}};
        end
        ST_GAIN: begin
          // Coefficient index already points at the next band's first tap.
          r_sum  <= r_sum + {{(SumW-ProdW){w_gsh[ProdW-1]}}, w_gsh};
          r_band <= r_band + BAND_ONE;
          r_k    <= {TapsBits{1'b0}};
          r_hidx <= r_wp;
        end
        ST_OUTPUT: begin
          r_y   <= sat_dw({{(AccW-SumW){r_sum[SumW-1]}}, r_sum});
          r_sum <= {SumW{1'b0}};
          r_wp  <= (r_wp == HIST_LAST) ? {HistW{1'b0}} : (r_wp + HIST_ONE);
        end
        default: ;
      endcase
    end
  end

  // Sample history: zeroed word by word while clearing, written on each accepted sample
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (r_state == ST_CLEAR) begin
        r_hist[r_clr] <= {DataWidth{1'b0}};
      end else if (w_sample) begin
        r_hist[r_wp] <= w_data;
      end
    end
  end

  // Coefficient RAM keeps its contents across reset
  always_ff @(posedge Clk) begin
    if (!Reset && w_acc && (w_op == OP_LOAD) && (r_cptr < w_coef_lim)) begin
      r_cram[r_cptr] <= w_data;
    end
  end

endmodule

// File: tb/tb_eq_fir_perif.sv
// Randomised self-checking bench for eq_fir_perif against a plain-arithmetic
// equalizer model (flat coefficient list, circular history, per-band gains).
module tb_eq_fir_perif;
  localparam int NB = 10;
  localparam int M  = 281;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_fir_perif_if bus();

  eq_fir_perif #(.NumBands(NB), .DataWidth(16), .TapsBits(9), .MaxTaps(M), .GainFrac(14)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // model state
  int m_hist [M];
  int m_cram [NB*M];
  int m_gain [NB];
  int m_wp, m_taps, m_cptr, m_y;
  bit m_ovf, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void m_reset();
    foreach (m_hist[i]) m_hist[i] = 0;
    foreach (m_gain[i]) m_gain[i] = 16384;
    m_wp = 0; m_taps = 1; m_cptr = 0; m_y = 0; m_ovf = 0; m_drop = 0;
  endfunction

  function automatic void m_sample(input int x);
    longint acc, sum, bv;
    m_hist[m_wp] = x;
    sum = 0;
    for (int b = 0; b < NB; b++) begin
      acc = 0;
      for (int k = 0; k < m_taps; k++)
        acc += longint'(m_cram[b*m_taps + k]) * longint'(m_hist[(m_wp - k + M) % M]);
      bv = sat16(acc >>> 15);
      sum += (bv * longint'(m_gain[b])) >>> 14;
    end
    m_y = int'(sat16(sum));
    m_wp = (m_wp + 1) % M;
  endfunction

  function automatic logic [31:0] exp_pr();
    logic [31:0] y32;
    y32 = m_y;
    return {1'b1, m_ovf, m_drop, 13'd0, y32[15:0]};
  endfunction

  task automatic send(input logic [31:0] w);
    bus.PSel = 1'b1; bus.PEnable = 1'b1; bus.PWrite = 1'b1; bus.PWData = w;
    @(negedge clk);
    bus.PSel = 1'b0; bus.PEnable = 1'b0; bus.PWrite = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.PRData[31] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_taps(input int v);
    logic [8:0] f;
    f = v[8:0];
    send({20'd0, f, 3'b001});
    if (v == 0 || v > M) m_ovf = 1'b1;
    else begin m_taps = v; m_cptr = 0; m_ovf = 1'b0; m_drop = 1'b0; end
  endtask

  task automatic load(input logic [15:0] h);
    send({13'd0, h, 3'b010});
    if (m_cptr < NB*m_taps) begin m_cram[m_cptr] = s16(h); m_cptr++; end
    else m_ovf = 1'b1;
  endtask

  task automatic set_gain(input int idx, input logic [15:0] g);
    logic [3:0] i4;
    i4 = idx[3:0];
    send({9'd0, i4, g, 3'b011});
    if (idx < NB) m_gain[idx] = s16(g);
  endtask

  task automatic sample(input logic [15:0] x, input string tag);
    int n;
    send({13'd0, x, 3'b100});
    m_sample(s16(x));
    wait_ready(n);
    chk({tag, "_lat"}, n, NB*(m_taps+2)+1);
    chk(tag, bus.PRData, exp_pr());
  endtask

  task automatic do_reset(input string tag);
    int n, bad;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk({tag, "_pr0"}, bus.PRData, 32'h0000_0000);
    n = 0; bad = 0;
    while (bus.PRData[31] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (bus.PRData[31] !== 1'b1 && bus.PRData !== 32'h0) bad++;
    end
    chk({tag, "_clr_len"}, n, M);
    chk({tag, "_clr_zero"}, bad, 0);
    chk({tag, "_ready"}, bus.PRData, 32'h8000_0000);
  endtask

  initial begin
    logic [15:0] exp2 [5];
    logic [31:0] w;
    int n, t;
    exp2 = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF, 16'h0000};
    foreach (m_cram[i]) m_cram[i] = 0;
    bus.PSel = 1'b0; bus.PEnable = 1'b0; bus.PWrite = 1'b0; bus.PWData = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset and clear sweep
    do_reset("rst1");

    // single band impulse response
    set_taps(4);
    load(16'h4000); load(16'h2000); load(16'h1000); load(16'h0800);
    for (int i = 4; i < NB*4; i++) load(16'h0000);
    for (int i = 0; i < 5; i++) begin
      sample((i == 0) ? 16'h7FFF : 16'h0000, "imp");
      chk("imp_const", {16'h0, bus.PRData[15:0]}, {16'h0, exp2[i]});
    end

    // saturation both directions with two hot bands
    set_taps(1);
    load(16'h7FFF); load(16'h7FFF);
    for (int i = 2; i < NB; i++) load(16'h0000);
    set_gain(0, 16'h7FFF); set_gain(1, 16'h7FFF);
    sample(16'h7FFF, "sat_pos");
    chk("sat_pos_const", {16'h0, bus.PRData[15:0]}, 32'h0000_7FFF);
    sample(16'h8000, "sat_neg");
    chk("sat_neg_const", {16'h0, bus.PRData[15:0]}, 32'h0000_8000);
    set_gain(0, 16'h4000); set_gain(1, 16'h4000);

    // coefficient overflow
    set_taps(4);
    for (int i = 0; i < NB*4; i++) load(16'($urandom_range(0, 65535)));
    chk("ovf_40", {31'd0, bus.PRData[30]}, 32'd0);
    load(16'($urandom_range(0, 65535)));
    chk("ovf_41", {31'd0, bus.PRData[30]}, 32'd1);
    sample(16'($urandom_range(0, 65535)), "ovf_samp");
    set_taps(4);
    chk("ovf_clr", {30'd0, bus.PRData[30:29]}, 32'd0);

    // randomised rounds: taps, coefficients, gains, ignored opcodes
    for (int r = 0; r < 4; r++) begin
      t = $urandom_range(1, 12);
      set_taps(t);
      for (int i = 0; i < NB*t; i++) load(16'($urandom_range(0, 65535)));
      for (int g = 0; g < 3; g++) set_gain($urandom_range(0, 15), 16'($urandom_range(0, 65535)));
      w = $urandom();
      case ($urandom_range(0, 3))
        0: w[2:0] = 3'b000;
        1: w[2:0] = 3'b101;
        2: w[2:0] = 3'b110;
        default: w[2:0] = 3'b111;
      endcase
      send(w);
      if (r == 1) set_taps(0);
      if (r == 2) set_taps(300);
      for (int s = 0; s < 5; s++) sample(16'($urandom_range(0, 65535)), "rnd");
    end

    // sample arriving during computation is dropped
    set_taps(3);
    for (int i = 0; i < NB*3; i++) load(16'($urandom_range(0, 65535)));
    send({13'd0, 16'h1234, 3'b100});
    m_sample(s16(16'h1234));
    repeat (3) @(negedge clk);
    send({13'd0, 16'h7777, 3'b100});
    m_drop = 1'b1;
    wait_ready(n);
    chk("drop_lat", n + 4, NB*5+1);
    chk("drop_pr", bus.PRData, exp_pr());

    // reset in the middle of MAC
    send({13'd0, 16'h4321, 3'b100});
    repeat (2) @(negedge clk);
    do_reset("rst_mid");

    // history wrap over MaxTaps+1 samples, then full-depth taps
    set_taps(8);
    for (int i = 0; i < NB*8; i++) load(16'($urandom_range(0, 65535)));
    for (int s = 0; s < M + 1; s++) sample(16'($urandom_range(0, 65535)), "wrap");
    set_taps(M);
    for (int i = 0; i < NB*M; i++) begin
      if (i == M - 1) load(16'h5A5B);
      else            load(16'($urandom_range(0, 65535)));
    end
    sample(16'($urandom_range(0, 65535)), "full0");
    sample(16'($urandom_range(0, 65535)), "full1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
